keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side counterpart of the multiplexed 7-segment/LED output path.
- Scans a 4x4 active-low key matrix by driving one column at a time, samples rows, debounces across full scan frames, and delivers one key code per press to the game controller over a valid/ready handshake.
- Sits between the board keypad pins and the controller's user-input interface.

Parameters:
- CLK_DIV, 1000, clock cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_CNT, 3, consecutive identical full frames required to accept a press or a release; minimum 1.
- REPEAT_DELAY, 50, frames a key must stay held before the first auto-repeat (only with KEYPAD_AUTOREPEAT_EN).
- REPEAT_RATE, 10, frames between subsequent auto-repeats (only with KEYPAD_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low: block is in reset while rst==0, sampled on posedge clk
- kp_col  output  4  column drive, one-cold (0 = column driven)
- kp_row  input  4  row sense, active-low, asynchronous pins with external pull-ups
- key_code  output  4  accepted key, encoded as row*4+col
- key_valid  output  1  key_code holds an unconsumed key
- key_ready  input  1  consumer accepts the key when key_valid && key_ready
- key_held  output  1  a debounced key is currently pressed
- key_ovf  output  1  sticky: a key was dropped because the previous key was still unconsumed

Behaviour:
- Reset (rst==0 at posedge clk): kp_col=4'b1111, key_code=0, key_valid=0, key_held=0, key_ovf=0. All counters clear, synchronizer clears to 4'b1111, FSM enters IDLE.
- Reset has priority over everything, including mid-scan, mid-debounce and pending valid.
- Row input passes through a 2-flop synchronizer before any use.
- Scan sequencing:
  - First cycle after reset release: kp_col=4'b1110 (col 0).
  - Dwell counter counts 0..CLK_DIV-1, then advances to the next column in order 0,1,2,3, wrapping to 0.
  - Synchronized rows are captured on the dwell cycle CLK_DIV-1, which allows a 2-cycle sync plus settling.
  - One frame = 4*CLK_DIV cycles. Frame result is evaluated on the cycle after column 3 is captured.
- Frame result:
  - No pressed bits: NONE.
  - Exactly one pressed bit across all 16 positions: SINGLE with code row*4+col.
  - Two or more pressed bits: MULTI, treated as NONE for acceptance but does not reset the held state.
- FSM, transitions evaluated only at frame boundaries:
  - IDLE: on SINGLE, latch candidate code, set deb_cnt=1, go to DEBOUNCE (if DEBOUNCE_CNT==1, accept immediately).
  - DEBOUNCE: same SINGLE code increments deb_cnt; on reaching DEBOUNCE_CNT, accept and go to PRESSED. A different code, NONE or MULTI returns to IDLE (a different SINGLE code restarts as a new candidate).
  - PRESSED: key_held=1. NONE starts the release count; DEBOUNCE_CNT consecutive NONE frames go to IDLE with key_held=0. SINGLE of the same code or MULTI clears the release count. A different SINGLE code is ignored until release.
- Accept action:
  - If key_valid==0, or key_valid && key_ready in the same cycle: key_code<=candidate, key_valid<=1.
  - Otherwise the key is dropped, key_ovf<=1 (sticky until reset), and key_code is unchanged.
- Handshake:
  - key_valid stays high and key_code stays stable until key_valid && key_ready.
  - key_valid falls the cycle after the handshake unless an accept coincides, in which case it stays high with the new code.
  - key_ready while key_valid==0 has no effect.
- Latency: key_valid rises exactly 1 cycle after the frame boundary that completes the debounce.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in PRESSED, a frame counter starts on entry. Reaching REPEAT_DELAY frames performs an accept action with the same code. Every subsequent REPEAT_RATE frames performs another accept. The counter clears on leaving PRESSED. Repeats are subject to the same overflow rule.
- Undefined: exactly one accept per press. REPEAT_* parameters are unused, and no repeat logic is synthesized.

Test Plan:
- Reset/scan (CLK_DIV=4): hold rst=0 for 5 cycles, release -> kp_col=1111 during reset, then 1110,1101,1011,0111 each for 4 cycles, wrap to 1110 at cycle 16; all outputs 0.
- Clean press (CLK_DIV=4, DEBOUNCE_CNT=3): row 2 low whenever col 1 is driven, key_ready=1 -> key_code=9 and a 1-cycle key_valid pulse 1 cycle after the 3rd stable frame boundary; key_held=1 until 3 NONE frames after release.
- Bounce: press pattern toggling every frame for 4 frames, then stable -> no key_valid until 3 consecutive stable frames; exactly one key_code=9.
- Multi-key: rows 0 and 3 low on col 2 -> no key_valid, FSM stays IDLE, key_held=0.
- Overflow (key_ready=0): press/release key 5, then press key 10 -> key_valid=1 with key_code=5 held stable, key_ovf=1; assert key_ready -> handshake completes, key_valid=0, key_ovf remains 1.
- Reset mid-operation: assert rst=0 while in DEBOUNCE with key_valid=1 -> next cycle all outputs at reset values; after release no stale key is delivered. With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2: held key 3 -> accepts at frames 0, 4, 6, 8 after entering PRESSED.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column scan, 2-flop row sync, frame debounce, valid/ready key delivery.
// Define KEYPAD_AUTOREPEAT_EN to enable auto-repeat of a held key (REPEAT_DELAY / REPEAT_RATE frames).
module keypad_scan #(
  parameter int CLK_DIV      = 1000,
  parameter int DEBOUNCE_CNT = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] kp_col,
  input  logic [3:0] kp_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_ovf
);

  localparam int DW_W  = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  if (CLK_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scan: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_e;
  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_e;

  function automatic logic [4:0] pop16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0000, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] enc16(input logic [15:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) if (v[i]) c = 4'(i);
    return c;
  endfunction

  logic [3:0]      row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic            run_q, run_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [1:0]      col_q, col_d;
  logic [15:0]     press_q, press_d;
  logic            frame_q, frame_d;

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d, rel_cnt_q, rel_cnt_d;
  logic [CNT_W-1:0] deb_inc, rel_inc;

  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_ovf_q, key_ovf_d;

  frame_e          fr_kind;
  logic [3:0]      fr_code;
  logic [4:0]      fr_pop;
  logic            accept;
  logic [3:0]      acc_code;
  logic            handshake;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RP_W-1:0] REP_FIRST = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] REP_NEXT  = RP_W'(REPEAT_DELAY + REPEAT_RATE);
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      run_q       <= 1'b0;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      press_q     <= '0;
      frame_q     <= 1'b0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_ovf_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      run_q       <= run_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      press_q     <= press_d;
      frame_q     <= frame_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_ovf_q   <= key_ovf_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  // Rows are captured on the last dwell cycle so the 2-flop sync has settled on the driven column.
  always_comb begin
    row_s1_d = kp_row;
    row_s2_d = row_s1_q;
    run_d    = 1'b1;
    dwell_d  = dwell_q;
    col_d    = col_q;
    press_d  = press_q;
    frame_d  = 1'b0;
    if (run_q) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        col_d   = col_q + 2'd1;
        for (int r = 0; r < 4; r++) press_d[r*4 + int'(col_q)] = ~row_s2_q[r];
        frame_d = (col_q == 2'd3);
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_comb begin
    fr_pop  = pop16(press_q);
    fr_code = enc16(press_q);
    if (fr_pop == 5'd0)      fr_kind = FR_NONE;
    else if (fr_pop == 5'd1) fr_kind = FR_SINGLE;
    else                     fr_kind = FR_MULTI;
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    deb_inc   = deb_cnt_q + 1'b1;
    rel_inc   = rel_cnt_q + 1'b1;
    accept    = 1'b0;
    acc_code  = cand_q;
    if (frame_q) begin
      case (state_q)
        IDLE: begin
          if (fr_kind == FR_SINGLE) begin
            cand_d    = fr_code;
            deb_cnt_d = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              accept    = 1'b1;
              acc_code  = fr_code;
              rel_cnt_d = '0;
              state_d   = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (fr_kind == FR_SINGLE && fr_code == cand_q) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_LAST) begin
              accept    = 1'b1;
              rel_cnt_d = '0;
              state_d   = PRESSED;
            end
          end else if (fr_kind == FR_SINGLE) begin
            cand_d    = fr_code;
            deb_cnt_d = CNT_ONE;
          end else begin
            deb_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        PRESSED: begin
          // A different single key while held is ignored until the held key is released.
          if (fr_kind == FR_NONE) begin
            if (rel_inc == DEB_LAST) begin
              rel_cnt_d = '0;
              deb_cnt_d = '0;
              state_d   = IDLE;
            end else begin
              rel_cnt_d = rel_inc;
            end
          end else if (fr_kind == FR_MULTI || fr_code == cand_q) begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_inc   = rep_cnt_q + 1'b1;
    rep_cnt_d = rep_cnt_q;
    if (state_q != PRESSED || state_d != PRESSED) begin
      rep_cnt_d = '0;
    end else if (frame_q) begin
      if (rep_inc == REP_FIRST) begin
        accept    = 1'b1;
        rep_cnt_d = rep_inc;
      end else if (rep_inc == REP_NEXT) begin
        accept    = 1'b1;
        rep_cnt_d = REP_FIRST;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
`endif
  end

  // A new key may replace the pending one only when the consumer takes it in the same cycle.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_ovf_d   = key_ovf_q;
    handshake   = key_valid_q && key_ready;
    if (accept) begin
      if (!key_valid_q || handshake) begin
        key_code_d  = acc_code;
        key_valid_d = 1'b1;
      end else begin
        key_ovf_d = 1'b1;
      end
    end else if (handshake) begin
      key_valid_d = 1'b0;
    end
  end

  always_comb begin
    kp_col    = run_q ? ~(4'b0001 << col_q) : 4'b1111;
    key_code  = key_code_q;
    key_valid = key_valid_q;
    key_held  = (state_q == PRESSED);
    key_ovf   = key_ovf_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: matrix model drives rows from kp_col, scoreboard checks delivered keys.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] kp_col;
  logic [3:0] kp_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       key_ovf;

  logic [15:0] keys = '0;
  logic [3:0]  exp_col;
  logic [3:0]  exp_code;
  logic [3:0]  sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = -1;

  keypad_scan #(
    .CLK_DIV(4),
    .DEBOUNCE_CNT(3),
    .REPEAT_DELAY(4),
    .REPEAT_RATE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp_col(kp_col),
    .kp_row(kp_row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held(key_held),
    .key_ovf(key_ovf)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  always @(posedge clk) cyc <= rst ? cyc + 1 : -1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && key_valid && key_ready) begin
      chk("sb_key_expected", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        exp_code = sb.pop_front();
        chk("sb_key_code", 16'(key_code), 16'(exp_code));
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    chk("sb_drained", 16'(sb.size()), 16'd0);
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_kp_col", 16'(kp_col), 16'hF);
    chk("rst_key_code", 16'(key_code), 16'd0);
    chk("rst_key_valid", 16'(key_valid), 16'd0);
    chk("rst_key_held", 16'(key_held), 16'd0);
    chk("rst_key_ovf", 16'(key_ovf), 16'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and scan sequence
    key_ready = 1'b1;
    keys = '0;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      wait_cyc(c);
      exp_col = ~(4'b0001 << ((c / 4) % 4));
      chk("scan_col", 16'(kp_col), 16'(exp_col));
    end
    chk("scan_valid", 16'(key_valid), 16'd0);
    chk("scan_held", 16'(key_held), 16'd0);
    chk("scan_code", 16'(key_code), 16'd0);

    // Clean press of key 9 (row 2, col 1)
    do_reset();
    keys = 16'h0200;
    sb.push_back(4'd9);
    wait_cyc(48);
    chk("clean_valid_early", 16'(key_valid), 16'd0);
    chk("clean_held_early", 16'(key_held), 16'd0);
    wait_cyc(49);
    chk("clean_valid", 16'(key_valid), 16'd1);
    chk("clean_code", 16'(key_code), 16'd9);
    chk("clean_held", 16'(key_held), 16'd1);
    wait_cyc(50);
    chk("clean_valid_drop", 16'(key_valid), 16'd0);
    wait_cyc(64);
    keys = '0;
    wait_cyc(112);
    chk("clean_held_release", 16'(key_held), 16'd1);
    wait_cyc(113);
    chk("clean_released", 16'(key_held), 16'd0);
    chk("clean_no_valid", 16'(key_valid), 16'd0);

    // Bounce: alternating frames, then stable
    do_reset();
    keys = 16'h0200;
    sb.push_back(4'd9);
    wait_cyc(16);  keys = '0;
    wait_cyc(32);  keys = 16'h0200;
    wait_cyc(48);  keys = '0;
    wait_cyc(64);  keys = 16'h0200;
    wait_cyc(81);
    chk("bounce_valid_f4", 16'(key_valid), 16'd0);
    chk("bounce_held_f4", 16'(key_held), 16'd0);
    wait_cyc(112);
    chk("bounce_valid_early", 16'(key_valid), 16'd0);
    wait_cyc(113);
    chk("bounce_valid", 16'(key_valid), 16'd1);
    chk("bounce_code", 16'(key_code), 16'd9);
    wait_cyc(128);
    keys = '0;
    wait_cyc(180);
    chk("bounce_released", 16'(key_held), 16'd0);

    // Two keys in column 2: never accepted
    do_reset();
    keys = 16'h4004;
    for (int f = 1; f <= 6; f++) begin
      wait_cyc(16 * f + 1);
      chk("multi_held", 16'(key_held), 16'd0);
      chk("multi_valid", 16'(key_valid), 16'd0);
    end
    keys = '0;

    // Overflow with consumer stalled
    key_ready = 1'b0;
    do_reset();
    keys = 16'h0020;
    sb.push_back(4'd5);
    wait_cyc(48);
    keys = '0;
    wait_cyc(49);
    chk("ovf_valid_first", 16'(key_valid), 16'd1);
    chk("ovf_code_first", 16'(key_code), 16'd5);
    chk("ovf_flag_clear", 16'(key_ovf), 16'd0);
    wait_cyc(96);
    keys = 16'h0400;
    wait_cyc(144);
    chk("ovf_flag_before", 16'(key_ovf), 16'd0);
    chk("ovf_code_before", 16'(key_code), 16'd5);
    wait_cyc(145);
    chk("ovf_flag_set", 16'(key_ovf), 16'd1);
    chk("ovf_code_stable", 16'(key_code), 16'd5);
    chk("ovf_valid_held", 16'(key_valid), 16'd1);
    wait_cyc(150);
    @(posedge clk);
    #1 key_ready = 1'b1;
    wait_cyc(152);
    chk("ovf_valid_done", 16'(key_valid), 16'd0);
    chk("ovf_flag_sticky", 16'(key_ovf), 16'd1);
    keys = '0;
    key_ready = 1'b0;

    // Reset while debouncing with a pending key
    do_reset();
    keys = 16'h0020;
    wait_cyc(48);
    keys = '0;
    wait_cyc(49);
    chk("midrst_valid", 16'(key_valid), 16'd1);
    chk("midrst_code", 16'(key_code), 16'd5);
    wait_cyc(96);
    keys = 16'h0040;
    wait_cyc(115);
    chk("midrst_pending", 16'(key_valid), 16'd1);
    chk("midrst_not_held", 16'(key_held), 16'd0);
    keys = '0;
    do_reset();
    key_ready = 1'b1;
    wait_cyc(100);
    chk("midrst_no_stale_valid", 16'(key_valid), 16'd0);
    chk("midrst_no_stale_code", 16'(key_code), 16'd0);
    chk("midrst_no_held", 16'(key_held), 16'd0);
    chk("midrst_no_ovf", 16'(key_ovf), 16'd0);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Held key 3 repeats at frames 0, 4, 6, 8, 10 after entering the pressed state
    do_reset();
    keys = 16'h0008;
    for (int i = 0; i < 5; i++) sb.push_back(4'd3);
    wait_cyc(49);
    chk("rep_first_valid", 16'(key_valid), 16'd1);
    chk("rep_first_code", 16'(key_code), 16'd3);
    wait_cyc(81);
    chk("rep_quiet_f2", 16'(key_valid), 16'd0);
    wait_cyc(113);
    chk("rep_delay_valid", 16'(key_valid), 16'd1);
    wait_cyc(129);
    chk("rep_quiet_f5", 16'(key_valid), 16'd0);
    wait_cyc(145);
    chk("rep_rate_valid_1", 16'(key_valid), 16'd1);
    wait_cyc(177);
    chk("rep_rate_valid_2", 16'(key_valid), 16'd1);
    wait_cyc(192);
    keys = '0;
    wait_cyc(260);
    chk("rep_released", 16'(key_held), 16'd0);
`endif

    wait_cyc(cyc + 2);
    chk("sb_final_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
